fle_carry_output_register_stage: RTL and testbench

//   Downstream stage of the fabric adder_carry chain inside frac_logic.

---
 rtl/fle_carry_output_register_stage_if.sv | 24 ++
 rtl/fle_carry_output_register_stage.sv | 58 +++++
 tb/tb_fle_carry_output_register_stage.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fle_carry_output_register_stage_if.sv
// Bus bundle for the carry output register stage: configuration chain, data
// inputs from the adder_carry slice and the selected outputs.
interface fle_carry_output_register_stage_if #(
  parameter int WIDTH = 4
);
  logic             config_enable;
  logic             ccff_head;
  logic             ccff_tail;
  logic             ce;
  logic [0:WIDTH-1] sumout;
  logic             cout_in;
  logic [0:WIDTH-1] sum_o;
  logic             cout_o;

  modport master (
    output config_enable, ccff_head, ce, sumout, cout_in,
    input  ccff_tail, sum_o, cout_o
  );

  modport slave (
    input  config_enable, ccff_head, ce, sumout, cout_in,
    output ccff_tail, sum_o, cout_o
  );
endinterface

// File: rtl/fle_carry_output_register_stage.sv
// Captures the adder_carry sumout bits and chain carry-out; each output is
// routed registered or combinational according to a scan-loaded config chain.
module fle_carry_output_register_stage #(
  parameter int WIDTH = 4
) (
  input logic                               clk,
  input logic                               reset,
  fle_carry_output_register_stage_if.slave  bus
);

  localparam int CFG_BITS = WIDTH + 2;

  logic [0:CFG_BITS-1] cfg;
  logic [0:WIDTH-1]    sum_q;
  logic                cout_q;
  logic                ce_eff;
  logic [0:WIDTH-1]    sum_sel;
  logic                cout_sel;

  // cfg[WIDTH+1] lets the data registers run every cycle regardless of ce.
  assign ce_eff = bus.ce | cfg[WIDTH+1];

  // Shift chain: new bit enters at cfg[0], so the first bit loaded ends at the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg <= '0;
    end else if (bus.config_enable) begin
      cfg <= {bus.ccff_head, cfg[0:CFG_BITS-2]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (!bus.config_enable && ce_eff) begin
      sum_q  <= bus.sumout;
      cout_q <= bus.cout_in;
    end
  end

  // Outputs are held at zero while the chain is shifting so partial configs never leak.
  always_comb begin
    sum_sel  = '0;
    cout_sel = 1'b0;
    if (!bus.config_enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        sum_sel[i] = cfg[i] ? sum_q[i] : bus.sumout[i];
      end
      cout_sel = cfg[WIDTH] ? cout_q : bus.cout_in;
    end
  end

  assign bus.sum_o     = sum_sel;
  assign bus.cout_o    = cout_sel;
  assign bus.ccff_tail = cfg[CFG_BITS-1];

endmodule

// File: tb/tb_fle_carry_output_register_stage.sv
// Randomized self-checking bench for fle_carry_output_register_stage using a
// queue-based reference model of the config chain and data registers.
module tb_fle_carry_output_register_stage;

  localparam int W   = 4;
  localparam int CFG = W + 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fle_carry_output_register_stage_if #(.WIDTH(W)) bus ();

  fle_carry_output_register_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cfg as a queue (index 0 = cfg[0]) plus captured data.
  bit           m_cfg[$];
  logic [0:W-1] m_sumq;
  logic         m_coutq;

  task automatic model_reset();
    m_cfg.delete();
    for (int k = 0; k < CFG; k++) m_cfg.push_back(1'b0);
    m_sumq  = '0;
    m_coutq = 1'b0;
  endtask

  function automatic logic [0:W-1] exp_sum();
    logic [0:W-1] r;
    r = '0;
    if (!bus.config_enable)
      for (int i = 0; i < W; i++) r[i] = m_cfg[i] ? m_sumq[i] : bus.sumout[i];
    return r;
  endfunction

  function automatic logic exp_cout();
    if (bus.config_enable) return 1'b0;
    return m_cfg[W] ? m_coutq : bus.cout_in;
  endfunction

  function automatic logic exp_tail();
    return m_cfg[CFG-1];
  endfunction

  // One rising edge: model follows the inputs that were stable before the edge.
  task automatic step();
    @(posedge clk);
    if (!reset) begin
      if (bus.config_enable) begin
        m_cfg.push_front(bus.ccff_head);
        void'(m_cfg.pop_back());
      end else if (bus.ce | m_cfg[W+1]) begin
        m_sumq  = bus.sumout;
        m_coutq = bus.cout_in;
      end
    end
    #1;
  endtask

  task automatic load_cfg(input logic [0:CFG-1] v);
    bus.config_enable = 1'b1;
    for (int k = CFG - 1; k >= 0; k--) begin
      bus.ccff_head = v[k];
      step();
    end
    bus.config_enable = 1'b0;
    bus.ccff_head     = 1'b0;
  endtask

  function automatic logic [0:W-1] rnd_vec();
    logic [31:0] r;
    r = $urandom;
    return r[W-1:0];
  endfunction

  task automatic test_reset();
    reset         = 1'b1;
    bus.sumout    = 4'b1010;
    bus.cout_in   = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (bus.sum_o !== 4'b1010) begin
      n_fail++; $display("[TB] FAIL reset_sum: got %b expected %b", bus.sum_o, 4'b1010);
    end
    n_checks++;
    if (bus.cout_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_cout: got %b expected 1", bus.cout_o);
    end
    n_checks++;
    if (bus.ccff_tail !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_tail: got %b expected 0", bus.ccff_tail);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_config_chain();
    logic [0:CFG-1] bits_in;
    bits_in = 6'b011111;
    bus.config_enable = 1'b1;
    for (int k = 0; k < CFG; k++) begin
      bus.ccff_head = bits_in[k];
      bus.sumout    = rnd_vec();
      bus.cout_in   = 1'b1;
      #1;
      n_checks++;
      if (bus.sum_o !== 4'b0000 || bus.cout_o !== 1'b0) begin
        n_fail++; $display("[TB] FAIL shift_isolation: got %b/%b expected 0000/0", bus.sum_o, bus.cout_o);
      end
      step();
      n_checks++;
      if (bus.ccff_tail !== exp_tail()) begin
        n_fail++; $display("[TB] FAIL shift_tail: got %b expected %b", bus.ccff_tail, exp_tail());
      end
    end
    bus.config_enable = 1'b0;
    n_checks++;
    if (bus.ccff_tail !== 1'b0) begin
      n_fail++; $display("[TB] FAIL load_tail: got %b expected 0", bus.ccff_tail);
    end
    bus.sumout  = 4'b0110;
    bus.cout_in = 1'b1;
    bus.ce      = 1'b1;
    step();
    bus.sumout  = rnd_vec();
    bus.cout_in = 1'b0;
    #1;
    n_checks++;
    if (bus.sum_o !== 4'b0110) begin
      n_fail++; $display("[TB] FAIL registered_sum: got %b expected %b", bus.sum_o, 4'b0110);
    end
    n_checks++;
    if (bus.cout_o !== exp_cout()) begin
      n_fail++; $display("[TB] FAIL registered_cout: got %b expected %b", bus.cout_o, exp_cout());
    end
  endtask

  task automatic test_ce_bypass();
    logic [0:W-1] prev;
    load_cfg(6'b111100);
    bus.ce     = 1'b1;
    bus.sumout = 4'b0000;
    step();
    bus.ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.sumout = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      step();
      n_checks++;
      if (bus.sum_o !== 4'b0000 || bus.sum_o !== exp_sum()) begin
        n_fail++; $display("[TB] FAIL ce_hold: got %b expected %b", bus.sum_o, 4'b0000);
      end
    end
    load_cfg(6'b111101);
    prev = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      bus.sumout = rnd_vec();
      #1;
      n_checks++;
      if (bus.sum_o !== exp_sum()) begin
        n_fail++; $display("[TB] FAIL bypass_model: got %b expected %b", bus.sum_o, exp_sum());
      end
      prev = bus.sumout;
      step();
      n_checks++;
      if (bus.sum_o !== prev) begin
        n_fail++; $display("[TB] FAIL bypass_lag: got %b expected %b", bus.sum_o, prev);
      end
    end
  endtask

  task automatic test_mixed();
    load_cfg(6'b101010);
    bus.ce     = 1'b1;
    bus.sumout = 4'b0000;
    step();
    bus.sumout = 4'b1111;
    #1;
    n_checks++;
    if (bus.sum_o !== 4'b0101) begin
      n_fail++; $display("[TB] FAIL mixed_before: got %b expected %b", bus.sum_o, 4'b0101);
    end
    step();
    n_checks++;
    if (bus.sum_o !== 4'b1111) begin
      n_fail++; $display("[TB] FAIL mixed_after: got %b expected %b", bus.sum_o, 4'b1111);
    end
    for (int k = 0; k < 10; k++) begin
      bus.sumout  = rnd_vec();
      bus.cout_in = 1'($urandom_range(0, 1));
      bus.ce      = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (bus.sum_o !== exp_sum() || bus.cout_o !== exp_cout()) begin
        n_fail++; $display("[TB] FAIL mixed_random: got %b/%b expected %b/%b", bus.sum_o, bus.cout_o, exp_sum(), exp_cout());
      end
      step();
    end
  endtask

  task automatic test_config_freeze();
    logic [0:CFG-1] v;
    v = 6'b111110;
    load_cfg(v);
    bus.ce     = 1'b1;
    bus.sumout = 4'b1011;
    step();
    n_checks++;
    if (bus.sum_o !== 4'b1011) begin
      n_fail++; $display("[TB] FAIL freeze_setup: got %b expected %b", bus.sum_o, 4'b1011);
    end
    bus.config_enable = 1'b1;
    for (int k = CFG - 1; k >= 0; k--) begin
      bus.ccff_head = v[k];
      bus.sumout    = rnd_vec();
      #1;
      n_checks++;
      if (bus.sum_o !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL freeze_isolation: got %b expected %b", bus.sum_o, 4'b0000);
      end
      step();
    end
    bus.config_enable = 1'b0;
    bus.ccff_head     = 1'b0;
    bus.sumout        = 4'b0000;
    #1;
    n_checks++;
    if (bus.sum_o !== 4'b1011) begin
      n_fail++; $display("[TB] FAIL freeze_hold: got %b expected %b", bus.sum_o, 4'b1011);
    end
    step();
    n_checks++;
    if (bus.sum_o !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL freeze_release: got %b expected %b", bus.sum_o, 4'b0000);
    end
  endtask

  task automatic test_reset_midload();
    bus.config_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.ccff_head = 1'b1;
      step();
      n_checks++;
      if (bus.ccff_tail !== exp_tail()) begin
        n_fail++; $display("[TB] FAIL partial_tail: got %b expected %b", bus.ccff_tail, exp_tail());
      end
    end
    bus.config_enable = 1'b0;
    bus.sumout        = rnd_vec();
    bus.cout_in       = ~m_coutq;
    reset             = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (bus.ccff_tail !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midload_tail: got %b expected 0", bus.ccff_tail);
    end
    n_checks++;
    if (bus.sum_o !== bus.sumout || bus.cout_o !== bus.cout_in) begin
      n_fail++; $display("[TB] FAIL midload_passthru: got %b/%b expected %b/%b", bus.sum_o, bus.cout_o, bus.sumout, bus.cout_in);
    end
    #2;
    reset = 1'b0;
    load_cfg(6'b111111);
    n_checks++;
    if (bus.ccff_tail !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reload_tail: got %b expected 1", bus.ccff_tail);
    end
    bus.ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.sumout  = rnd_vec();
      bus.cout_in = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if (bus.sum_o !== exp_sum() || bus.cout_o !== exp_cout()) begin
        n_fail++; $display("[TB] FAIL reload_data: got %b/%b expected %b/%b", bus.sum_o, bus.cout_o, exp_sum(), exp_cout());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.config_enable = ($urandom_range(0, 5) == 0);
      bus.ccff_head     = 1'($urandom_range(0, 1));
      bus.ce            = 1'($urandom_range(0, 1));
      bus.sumout        = rnd_vec();
      bus.cout_in       = 1'($urandom_range(0, 1));
      #1;
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
      end
      n_checks++;
      if (bus.sum_o !== exp_sum() || bus.cout_o !== exp_cout() || bus.ccff_tail !== exp_tail()) begin
        n_fail++; $display("[TB] FAIL random_cycle%0d: got %b/%b/%b expected %b/%b/%b", k,
                           bus.sum_o, bus.cout_o, bus.ccff_tail, exp_sum(), exp_cout(), exp_tail());
      end
      reset = 1'b0;
      step();
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    reset             = 1'b1;
    bus.config_enable = 1'b0;
    bus.ccff_head     = 1'b0;
    bus.ce            = 1'b0;
    bus.sumout        = '0;
    bus.cout_in       = 1'b0;
    model_reset();
    test_reset();
    test_config_chain();
    test_ce_bypass();
    test_mixed();
    test_config_freeze();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
